// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants (active-low, bit6=g .. bit0=a) used by the
// hex encoder and the scan decoder.
package sevenseg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic [6:0]            seg;
    } bus_sample_t;

    function automatic logic one_hot_low(input logic [NUM_DIGITS-1:0] an);
        logic [NUM_DIGITS-1:0] inv;
        inv = ~an;
        return (inv != '0) && ((inv & (inv - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/sevenseg_scan_decoder_if.sv
// Multiplexed seven-segment display bus: the driver is the master, readers are slaves.
interface sevenseg_scan_decoder_if import sevenseg_pkg::*;;
    logic [6:0]            seg_L;
    logic [NUM_DIGITS-1:0] an_L;

    modport master (output seg_L, output an_L);
    modport slave  (input  seg_L, input  an_L);
endinterface

// File: rtl/sevenseg_pattern_decode.sv
// Combinational inverse of the package segment table; hex reads 0 for any non-hex pattern.
module sevenseg_pattern_decode import sevenseg_pkg::*; (
    input  logic [6:0] seg_L,
    output logic [3:0] hex,
    output logic       is_hex,
    output logic       is_blank
);

    always_comb begin
        hex      = '0;
        is_hex   = 1'b1;
        is_blank = 1'b0;
        case (seg_L)
            SEG_0:     hex = 4'h0;
            SEG_1:     hex = 4'h1;
            SEG_2:     hex = 4'h2;
            SEG_3:     hex = 4'h3;
            SEG_4:     hex = 4'h4;
            SEG_5:     hex = 4'h5;
            SEG_6:     hex = 4'h6;
            SEG_7:     hex = 4'h7;
            SEG_8:     hex = 4'h8;
            SEG_9:     hex = 4'h9;
            SEG_A:     hex = 4'hA;
            SEG_B:     hex = 4'hB;
            SEG_C:     hex = 4'hC;
            SEG_D:     hex = 4'hD;
            SEG_E:     hex = 4'hE;
            SEG_F:     hex = 4'hF;
            SEG_BLANK: begin
                is_hex   = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_hex = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Recovers the 4-digit hex value shown on a scanned active-low seven-segment bus,
// committing a digit only after it has been stable for STABLE_CNT samples.
module sevenseg_scan_decoder import sevenseg_pkg::*; #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    sevenseg_scan_decoder_if.slave    seg_bus,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_valid,
    output logic                      bad_pattern,
    output logic                      anode_err
);

    localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

    bus_sample_t           sample_q;
    bus_sample_t           sample_p;
    logic [CNT_W-1:0]      count;
    logic [NUM_DIGITS-1:0] flags;

    logic                  one_hot;
    logic                  multi_low;
    logic                  same;
    logic                  commit;
    logic [NUM_DIGITS-1:0] commit_vec;
    logic [1:0]            idx;
    logic [3:0]            hex;
    logic                  is_hex;
    logic                  is_blank;

    sevenseg_pattern_decode u_decode (
        .seg_L    (sample_q.seg),
        .hex      (hex),
        .is_hex   (is_hex),
        .is_blank (is_blank)
    );

    always_comb begin
        one_hot    = one_hot_low(sample_q.an);
        multi_low  = (~sample_q.an != '0) && !one_hot;
        same       = (sample_q == sample_p);
        commit     = one_hot && same && (count == CNT_PRE);
        commit_vec = commit ? ~sample_q.an : '0;
        idx        = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!sample_q.an[i]) idx = 2'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q    <= '1;
            sample_p    <= '1;
            count       <= '0;
            value       <= '0;
            digit_valid <= '0;
            flags       <= '0;
            frame_valid <= 1'b0;
            bad_pattern <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            sample_q    <= '{an: seg_bus.an_L, seg: seg_bus.seg_L};
            sample_p    <= sample_q;
            anode_err   <= multi_low;
            bad_pattern <= commit && !is_hex && !is_blank;

            if (!one_hot)              count <= '0;
            else if (!same)            count <= CNT_ONE;
            else if (count != CNT_MAX) count <= count + CNT_ONE;

            if (commit) begin
                // hex is 0 for blank, so one write covers both hex and blank
                if (is_hex || is_blank) value[4*idx +: 4] <= hex;
                digit_valid[idx] <= is_hex;
            end

            // A flag set on the clearing edge is kept so its digit counts toward the next frame
            if (&flags) begin
                frame_valid <= 1'b1;
                flags       <= commit_vec;
            end else begin
                frame_valid <= 1'b0;
                flags       <= flags | commit_vec;
            end
        end
    end

endmodule
